// File: rtl/window_fetch_ctrl_pkg.sv
// window_fetch_ctrl_pkg: shared image geometry, FSM state encoding and 3x3 tap offset tables.
//   IMG_W/IMG_H : default image size in pixels (IMG_W a power of two)
//   AW/DW       : pixel index / ROM address width and pixel data width
//   LAST_PIX    : index of the final pixel of a default-sized frame
//   tap_row/col : position of tap k inside the window (0..2); offset from centre is value-1
package window_fetch_ctrl_pkg;
    localparam int IMG_W    = 128;
    localparam int IMG_H    = 128;
    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int LAST_PIX = IMG_W * IMG_H - 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_OUT, S_ADV, S_DONE} state_t;

    function automatic logic [1:0] tap_row(input logic [3:0] k);
        return (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] tap_col(input logic [3:0] k);
        return (k == 4'd0 || k == 4'd3 || k == 4'd6) ? 2'd0 :
               (k == 4'd1 || k == 4'd4 || k == 4'd7) ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/window_fetch_ctrl_nb_addr_calc.sv
// nb_addr_calc: combinational neighbour address and border test for one 3x3 tap.
//   count     in  AW : centre pixel index (row-major)
//   k         in  4  : tap index 0..8, row-major, 0 = top-left
//   rd_addr   out AW : ROM address of the tap (meaningful only when in_bounds)
//   in_bounds out 1  : tap lies inside the image (no wrap between rows)
module nb_addr_calc #(
    parameter int IMG_W = window_fetch_ctrl_pkg::IMG_W,
    parameter int IMG_H = window_fetch_ctrl_pkg::IMG_H,
    parameter int AW    = window_fetch_ctrl_pkg::AW
) (
    input  logic [AW-1:0] count,
    input  logic [3:0]    k,
    output logic [AW-1:0] rd_addr,
    output logic          in_bounds
);
    import window_fetch_ctrl_pkg::*;

    localparam int            LW       = $clog2(IMG_W);
    localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - 1);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);

    logic [AW-1:0] row;
    logic [AW-1:0] col;
    logic [1:0]    tr;
    logic [1:0]    tc;

    always_comb begin
        row = count >> LW;
        col = count & COL_LAST;
        tr  = tap_row(k);
        tc  = tap_col(k);
        // each border only excludes taps that step outward across it
        in_bounds = !(tr == 2'd0 && row == '0) && !(tr == 2'd2 && row == ROW_LAST) &&
                    !(tc == 2'd0 && col == '0) && !(tc == 2'd2 && col == COL_LAST);
        // count + (tr-1)*IMG_W + (tc-1), done modulo 2**AW
        rd_addr = count + (AW'(tr) << LW) + AW'(tc) - AW'(IMG_W) - AW'(1);
    end
endmodule

// File: rtl/window_fetch_ctrl.sv
// window_fetch_ctrl: raster-scan 3x3 window fetcher with zero padding and valid/ready output.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a frame (only honoured in IDLE)
//   count               : centre pixel index from the external pixel counter
//   clear, keep         : counter control (clear to 0 / hold; keep=0 increments)
//   rd_en, rd_addr      : synchronous ROM read; rd_data arrives the following cycle
//   win_data, win_valid : 3x3 window, tap k at [DW*k +: DW]; held until win_ready
//   busy, done          : frame in progress / one-cycle end-of-frame pulse
module window_fetch_ctrl #(
    parameter int IMG_W = window_fetch_ctrl_pkg::IMG_W,
    parameter int IMG_H = window_fetch_ctrl_pkg::IMG_H,
    parameter int AW    = window_fetch_ctrl_pkg::AW,
    parameter int DW    = window_fetch_ctrl_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   count,
    output logic            clear,
    output logic            keep,
    output logic            rd_en,
    output logic [AW-1:0]   rd_addr,
    input  logic [DW-1:0]   rd_data,
    output logic [9*DW-1:0] win_data,
    output logic            win_valid,
    input  logic            win_ready,
    output logic            busy,
    output logic            done
);
    import window_fetch_ctrl_pkg::*;

    localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);

    state_t          state_q, state_d;
    logic [3:0]      k_q, k_d;
    logic [3:0]      kd_q, kd_d;
    logic            inb_q, inb_d;
    logic            cap_q, cap_d;
    logic [9*DW-1:0] win_q, win_d;
    logic [AW-1:0]   nb_addr;
    logic            nb_inb;

    nb_addr_calc #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_addr (
        .count     (count),
        .k         (k_q),
        .rd_addr   (nb_addr),
        .in_bounds (nb_inb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            kd_q    <= '0;
            inb_q   <= 1'b0;
            cap_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            kd_q    <= kd_d;
            inb_q   <= inb_d;
            cap_q   <= cap_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        kd_d      = k_q;
        inb_d     = nb_inb;
        cap_d     = 1'b0;
        win_d     = win_q;
        clear     = 1'b0;
        keep      = 1'b1;
        rd_en     = 1'b0;
        rd_addr   = '0;
        win_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        // the tap issued last cycle lands now: ROM data if it was read, else padding
        if (cap_q)
            win_d[DW*kd_q +: DW] = inb_q ? rd_data : '0;
        case (state_q)
            S_IDLE: begin
                clear = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    state_d = S_FETCH;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                rd_en   = nb_inb;
                rd_addr = nb_inb ? nb_addr : '0;
                cap_d   = 1'b1;
                k_d     = k_q + 4'd1;
                state_d = (k_q == 4'd8) ? S_WAIT : S_FETCH;
            end
            S_WAIT: state_d = S_OUT;
            S_OUT: begin
                win_valid = 1'b1;
                if (win_ready)
                    state_d = (count == LAST) ? S_DONE : S_ADV;
            end
            S_ADV: begin
                keep    = 1'b0;
                k_d     = '0;
                state_d = S_FETCH;
            end
            S_DONE: begin
                clear   = 1'b1;
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign win_data = win_q;
endmodule
